spi_slave_rx: RTL

Receive-side SPI slave that deserialises the `cs`/`sclk`/`mosi` stream produced by the SPI master into parallel words. It sits directly downstream of the `spi` master, either in a loopback/self-check path or as the front end of a peripheral model. It synchronises the three SPI lines into the system clock domain, frames words on chip-select, flags malformed frames, and presents each word through a valid/ready handshake backed by one holding register.

---
 rtl/spi_slave_rx.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/spi_slave_rx.sv
// rtl/spi_slave_rx.sv - SPI mode-0 receive slave: synchronised cs/sclk/mosi to parallel words
// Frames one DW-bit word per chip-select window and hands it off through a single holding register.
module spi_slave_rx #(
  parameter int DW          = 12,
  parameter int SYNC_STAGES = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cs,
  input  logic          sclk,
  input  logic          mosi,
  output logic [DW-1:0] dout,
  output logic          dout_valid,
  input  logic          dout_ready,
  output logic          frame_err,
  output logic          overrun,
  output logic          busy
);

  localparam int CW = $clog2(DW + 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SHIFT    = 2'd1,
    WAIT_END = 2'd2
  } state_t;

  logic [SYNC_STAGES-1:0] cs_sync_q;
  logic [SYNC_STAGES-1:0] sclk_sync_q;
  logic [SYNC_STAGES-1:0] mosi_sync_q;
  logic                   cs_dly_q;
  logic                   sclk_dly_q;

  logic                   cs_s;
  logic                   sclk_s;
  logic                   mosi_s;
  logic                   sclk_rise;
  logic                   cs_fall;
  logic                   cs_rise;

  state_t                 state_q;
  logic [CW-1:0]          bit_cnt_q;
  logic [DW-2:0]          sr_q;
  logic                   frame_err_q;
  logic                   busy_q;

  logic [DW-1:0]          dout_q;
  logic                   dout_valid_q;
  logic                   overrun_q;

  logic                   last_bit;
  logic                   deliver;
  logic [DW-1:0]          word_d;

  // Reset to 0 so a cs held low through reset release never looks like a falling edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cs_sync_q   <= '0;
      sclk_sync_q <= '0;
      mosi_sync_q <= '0;
      cs_dly_q    <= 1'b0;
      sclk_dly_q  <= 1'b0;
    end else begin
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs};
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
      cs_dly_q    <= cs_s;
      sclk_dly_q  <= sclk_s;
    end
  end

  assign cs_s      = cs_sync_q[SYNC_STAGES-1];
  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];

  assign sclk_rise = sclk_s & ~sclk_dly_q;
  assign cs_fall   = ~cs_s & cs_dly_q;
  assign cs_rise   = cs_s & ~cs_dly_q;

  assign last_bit  = (bit_cnt_q == CW'(DW - 1));
  assign deliver   = (state_q == SHIFT) && !cs_rise && sclk_rise && last_bit;
  assign word_d    = {sr_q, mosi_s};

  // cs_rise is tested before sclk_rise in every state so it wins a same-cycle collision.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      sr_q        <= '0;
      frame_err_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      frame_err_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (cs_fall) begin
            state_q   <= SHIFT;
            bit_cnt_q <= '0;
            sr_q      <= '0;
            busy_q    <= 1'b1;
          end
        end
        SHIFT: begin
          if (cs_rise) begin
            frame_err_q <= 1'b1;
            state_q     <= IDLE;
            busy_q      <= 1'b0;
          end else if (sclk_rise) begin
            sr_q <= {sr_q[DW-3:0], mosi_s};
            if (last_bit) begin
              state_q <= WAIT_END;
            end else begin
              bit_cnt_q <= bit_cnt_q + CW'(1);
            end
          end
        end
        WAIT_END: begin
          if (cs_rise) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else if (sclk_rise) begin
            frame_err_q <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // A full register only takes a new word when the old one leaves in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      overrun_q <= 1'b0;
      if (deliver) begin
        if (!dout_valid_q || dout_ready) begin
          dout_q       <= word_d;
          dout_valid_q <= 1'b1;
        end else begin
          overrun_q <= 1'b1;
        end
      end else if (dout_valid_q && dout_ready) begin
        dout_valid_q <= 1'b0;
      end
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;
  assign busy       = busy_q;

endmodule
